// File: rtl/sw_array_driver.sv
// Feed/collect driver at both ends of the Smith-Waterman PE array.
// Optional watchdog result path: define SW_DRV_TIMEOUT_EN.
module sw_array_driver #(
  parameter int SCORE_WIDTH = 12,
  parameter int LEN_WIDTH   = 10,
  parameter int GAP_CYCLES  = 2,
  parameter int N_PE        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tgt_valid,
  output logic                   tgt_ready,
  input  logic [1:0]             tgt_base,
  input  logic                   tgt_last,
  output logic [1:0]             pe_data,
  output logic                   pe_en,
  output logic [SCORE_WIDTH-1:0] pe_M,
  output logic [SCORE_WIDTH-1:0] pe_I,
  output logic [SCORE_WIDTH-1:0] pe_High,
  input  logic                   arr_vld,
  input  logic [SCORE_WIDTH-1:0] arr_high,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [SCORE_WIDTH-2:0] res_score,
  output logic [LEN_WIDTH-1:0]   res_len,
  output logic                   res_timeout,
  output logic [1:0]             outstanding,
  output logic                   err_underrun,
  output logic                   err_spurious
);

  localparam logic [SCORE_WIDTH-1:0] ZERO =
    {1'b1, {(SCORE_WIDTH-1){1'b0}}};
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    GAP
  } state_t;

  state_t               state_q, state_d;
  logic                 pe_en_q, pe_en_d;
  logic [1:0]           pe_data_q, pe_data_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, len_inc;
  logic [3:0]           gap_q, gap_d;
  logic                 seq_end;
  logic [LEN_WIDTH-1:0] end_len;
  logic                 set_un;
  logic                 err_un_q, err_sp_q;

  logic [1:0]           lq_cnt;
  logic [LEN_WIDTH-1:0] lq_len [2];
  logic                 lq_pop;
  logic                 lq_wi;

  logic [1:0]             rq_cnt;
  logic [SCORE_WIDTH-2:0] rq_score [2];
  logic [LEN_WIDTH-1:0]   rq_len [2];
  logic                   rq_push, rq_pop;
  logic                   rq_wi;
  logic [SCORE_WIDTH-2:0] push_score;
  logic                   spurious;

`ifdef SW_DRV_TIMEOUT_EN
  localparam int TO_CYC = N_PE + 8;
  localparam int AW = $clog2(TO_CYC);
  localparam logic [AW-1:0] TO_LAST = AW'(TO_CYC - 1);
  logic [AW-1:0] lq_age [2];
  logic [AW-1:0] age_n [2];
  logic          to_fire;
  logic          rq_to [2];
`endif

  assign pe_M    = ZERO;
  assign pe_I    = ZERO;
  assign pe_High = ZERO;
  assign pe_en   = pe_en_q;
  assign pe_data = pe_data_q;

  assign outstanding  = lq_cnt + rq_cnt;
  assign err_underrun = err_un_q;
  assign err_spurious = err_sp_q;

  assign len_inc = (len_q == LEN_MAX) ? len_q
                 : len_q + LEN_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    pe_en_d   = 1'b0;
    pe_data_d = pe_data_q;
    len_d     = len_q;
    gap_d     = gap_q;
    tgt_ready = 1'b0;
    seq_end   = 1'b0;
    end_len   = len_q;
    set_un    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tgt_ready = (outstanding != 2'd2);
        if (tgt_valid && (outstanding != 2'd2)) begin
          pe_en_d   = 1'b1;
          pe_data_d = tgt_base;
          len_d     = LEN_WIDTH'(1);
          if (tgt_last) begin
            seq_end = 1'b1;
            end_len = LEN_WIDTH'(1);
            gap_d   = 4'd0;
            state_d = GAP;
          end else begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        tgt_ready = 1'b1;
        if (tgt_valid) begin
          pe_en_d   = 1'b1;
          pe_data_d = tgt_base;
          len_d     = len_inc;
          if (tgt_last) begin
            seq_end = 1'b1;
            end_len = len_inc;
            gap_d   = 4'd0;
            state_d = GAP;
          end
        end else begin
          // PEs cannot stall: close the sequence, drop the rest
          set_un  = 1'b1;
          seq_end = 1'b1;
          end_len = len_q;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        tgt_ready = 1'b1;
        if (tgt_valid && tgt_last) begin
          gap_d   = 4'd0;
          state_d = GAP;
        end
      end
      GAP: begin
        gap_d = gap_q + 4'd1;
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      pe_en_q   <= 1'b0;
      pe_data_q <= 2'b00;
      len_q     <= '0;
      gap_q     <= 4'd0;
      err_un_q  <= 1'b0;
      err_sp_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pe_en_q   <= pe_en_d;
      pe_data_q <= pe_data_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      err_un_q  <= err_un_q | set_un;
      err_sp_q  <= err_sp_q | spurious;
    end
  end

  always_comb begin
    spurious   = arr_vld && (lq_cnt == 2'd0);
    rq_push    = arr_vld && (lq_cnt != 2'd0);
    push_score = arr_high[SCORE_WIDTH-1]
               ? arr_high[SCORE_WIDTH-2:0] : '0;
`ifdef SW_DRV_TIMEOUT_EN
    to_fire = !arr_vld && (lq_cnt != 2'd0) &&
              (lq_age[0] == TO_LAST);
    if (to_fire) begin
      rq_push    = 1'b1;
      push_score = '0;
    end
`endif
  end

  assign lq_pop    = rq_push;
  assign rq_pop    = res_valid && res_ready;
  // write slot after any same-cycle shift
  assign lq_wi     = lq_cnt[0] ^ lq_pop;
  assign rq_wi     = rq_cnt[0] ^ rq_pop;
  assign res_valid = (rq_cnt != 2'd0);
  assign res_score = rq_score[0];
  assign res_len   = rq_len[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      lq_cnt    <= 2'd0;
      lq_len[0] <= '0;
      lq_len[1] <= '0;
    end else begin
      if (lq_pop) begin
        lq_len[0] <= lq_len[1];
      end
      if (seq_end) begin
        lq_len[lq_wi] <= end_len;
      end
      lq_cnt <= lq_cnt + {1'b0, seq_end} - {1'b0, lq_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rq_cnt      <= 2'd0;
      rq_score[0] <= '0;
      rq_score[1] <= '0;
      rq_len[0]   <= '0;
      rq_len[1]   <= '0;
    end else begin
      if (rq_pop) begin
        rq_score[0] <= rq_score[1];
        rq_len[0]   <= rq_len[1];
      end
      if (rq_push) begin
        rq_score[rq_wi] <= push_score;
        rq_len[rq_wi]   <= lq_len[0];
      end
      rq_cnt <= rq_cnt + {1'b0, rq_push} - {1'b0, rq_pop};
    end
  end

`ifdef SW_DRV_TIMEOUT_EN
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      age_n[i] = (lq_age[i] == TO_LAST) ? lq_age[i]
               : lq_age[i] + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lq_age[0] <= '0;
      lq_age[1] <= '0;
      rq_to[0]  <= 1'b0;
      rq_to[1]  <= 1'b0;
    end else begin
      lq_age[0] <= lq_pop ? age_n[1] : age_n[0];
      lq_age[1] <= age_n[1];
      if (seq_end) begin
        lq_age[lq_wi] <= '0;
      end
      if (rq_pop) begin
        rq_to[0] <= rq_to[1];
      end
      if (rq_push) begin
        rq_to[rq_wi] <= to_fire;
      end
    end
  end

  assign res_timeout = rq_to[0];
`else
  assign res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sw_array_driver.sv
// Self-checking bench for sw_array_driver: vector table plus
// hand-written underrun, backpressure, spurious and reset sequences.
module tb_sw_array_driver;

  localparam int SW = 12;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tgt_valid = 1'b0;
  logic          tgt_ready;
  logic [1:0]    tgt_base = 2'b00;
  logic          tgt_last = 1'b0;
  logic [1:0]    pe_data;
  logic          pe_en;
  logic [SW-1:0] pe_M, pe_I, pe_High;
  logic          arr_vld = 1'b0;
  logic [SW-1:0] arr_high = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [SW-2:0] res_score;
  logic [LW-1:0] res_len;
  logic          res_timeout;
  logic [1:0]    outstanding;
  logic          err_underrun, err_spurious;

  always #5 clk = ~clk;

  sw_array_driver #(
    .SCORE_WIDTH(SW),
    .LEN_WIDTH(LW),
    .GAP_CYCLES(2),
    .N_PE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .tgt_base(tgt_base),
    .tgt_last(tgt_last),
    .pe_data(pe_data),
    .pe_en(pe_en),
    .pe_M(pe_M),
    .pe_I(pe_I),
    .pe_High(pe_High),
    .arr_vld(arr_vld),
    .arr_high(arr_high),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_score(res_score),
    .res_len(res_len),
    .res_timeout(res_timeout),
    .outstanding(outstanding),
    .err_underrun(err_underrun),
    .err_spurious(err_spurious)
  );

  typedef struct packed {
    logic [SW-2:0] score;
    logic [LW-1:0] len;
    logic          to;
  } res_t;

  typedef struct {
    logic [15:0]   bases;
    int            n;
    logic [SW-1:0] high;
    logic [SW-2:0] score;
  } vec_t;

  res_t exp_q[$];
  res_t mon_e;
  vec_t vecs[5];
  int   n_chk = 0;
  int   n_fail = 0;
  int   en_cnt = 0;
  int   exp_en = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // scoreboard side: every enabled cycle and every popped result
  always @(negedge clk) begin
    if (pe_en) en_cnt++;
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL res_unexpected: score %0h len %0d, none pending",
                 res_score, res_len);
      end else begin
        mon_e = exp_q.pop_front();
        chk("res_score", 32'(res_score), 32'(mon_e.score));
        chk("res_len", 32'(res_len), 32'(mon_e.len));
        chk("res_timeout", 32'(res_timeout), 32'(mon_e.to));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] b, input logic last,
                      input logic issued);
    int k;
    tgt_valid = 1'b1;
    tgt_base  = b;
    tgt_last  = last;
    k = 0;
    while (!tgt_ready && k < 50) begin
      step();
      k++;
    end
    if (!tgt_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL beat_ready_timeout: tgt_ready %0b, required 1",
               tgt_ready);
    end
    step();
    tgt_valid = 1'b0;
    tgt_last  = 1'b0;
    if (issued) exp_en++;
    chk("beat_pe_en", 32'(pe_en), 32'(issued));
    if (issued) chk("beat_pe_data", 32'(pe_data), 32'(b));
  endtask

  task automatic send_seq(input logic [15:0] bases, input int n);
    for (int i = 0; i < n; i++) begin
      beat(bases[2*i +: 2], (i == n - 1), 1'b1);
    end
  endtask

  task automatic pulse(input logic [SW-1:0] h);
    arr_vld  = 1'b1;
    arr_high = h;
    step();
    arr_vld  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'h00E4, 4, 12'h80A, 11'h00A};
    vecs[1] = '{16'h0003, 1, 12'h7F0, 11'h000};
    vecs[2] = '{16'h1B1B, 8, 12'hFFF, 11'h7FF};
    vecs[3] = '{16'h0009, 2, 12'h800, 11'h000};
    vecs[4] = '{16'h0136, 5, 12'h923, 11'h123};

    rst = 1'b0;
    repeat (2) step();
    chk("rst_pe_en", 32'(pe_en), 32'd0);
    chk("rst_pe_data", 32'(pe_data), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_err_underrun", 32'(err_underrun), 32'd0);
    chk("rst_err_spurious", 32'(err_spurious), 32'd0);
    chk("seed_M", 32'(pe_M), 32'h800);
    chk("seed_I", 32'(pe_I), 32'h800);
    chk("seed_High", 32'(pe_High), 32'h800);
    rst = 1'b1;
    step();
    chk("idle_ready", 32'(tgt_ready), 32'd1);

    res_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      exp_q.push_back('{score: vecs[v].score,
                        len: LW'(vecs[v].n), to: 1'b0});
      send_seq(vecs[v].bases, vecs[v].n);
      chk("tbl_outstanding_1", 32'(outstanding), 32'd1);
      pulse(vecs[v].high);
      chk("tbl_gap_pe_en", 32'(pe_en), 32'd0);
      chk("tbl_gap_ready", 32'(tgt_ready), 32'd0);
      drain();
      chk("tbl_idle_pe_en", 32'(pe_en), 32'd0);
      chk("tbl_outstanding_0", 32'(outstanding), 32'd0);
    end

    // two sequences outstanding stall the third
    res_ready = 1'b0;
    beat(2'b00, 1'b1, 1'b1);
    beat(2'b01, 1'b1, 1'b1);
    exp_q.push_back('{score: 11'h005, len: LW'(1), to: 1'b0});
    exp_q.push_back('{score: 11'h006, len: LW'(1), to: 1'b0});
    pulse(12'h805);
    pulse(12'h806);
    chk("bp_outstanding_2", 32'(outstanding), 32'd2);
    chk("bp_res_valid", 32'(res_valid), 32'd1);
    tgt_valid = 1'b1;
    tgt_base  = 2'b10;
    tgt_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_stall_ready", 32'(tgt_ready), 32'd0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp_ready_after_pop", 32'(tgt_ready), 32'd1);
    chk("bp_outstanding_1", 32'(outstanding), 32'd1);
    beat(2'b10, 1'b1, 1'b1);
    exp_q.push_back('{score: 11'h007, len: LW'(1), to: 1'b0});
    pulse(12'h807);
    res_ready = 1'b1;
    drain();
    chk("bp_outstanding_0", 32'(outstanding), 32'd0);

    // underrun after two beats of a five-beat sequence
    beat(2'b00, 1'b0, 1'b1);
    beat(2'b01, 1'b0, 1'b1);
    step();
    chk("ur_pe_en", 32'(pe_en), 32'd0);
    chk("ur_err", 32'(err_underrun), 32'd1);
    chk("ur_outstanding", 32'(outstanding), 32'd1);
    beat(2'b10, 1'b0, 1'b0);
    beat(2'b11, 1'b0, 1'b0);
    beat(2'b00, 1'b1, 1'b0);
    exp_q.push_back('{score: 11'h015, len: LW'(2), to: 1'b0});
    pulse(12'h815);
    drain();
    chk("ur_outstanding_0", 32'(outstanding), 32'd0);

    // pulse with nothing outstanding
    pulse(12'h812);
    chk("sp_res_valid", 32'(res_valid), 32'd0);
    chk("sp_err", 32'(err_spurious), 32'd1);

    // reset mid-stream with a result parked
    res_ready = 1'b0;
    beat(2'b11, 1'b1, 1'b1);
    pulse(12'h899);
    chk("rs_parked", 32'(res_valid), 32'd1);
    beat(2'b00, 1'b0, 1'b1);
    beat(2'b01, 1'b0, 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rs_pe_en", 32'(pe_en), 32'd0);
    chk("rs_pe_data", 32'(pe_data), 32'd0);
    chk("rs_res_valid", 32'(res_valid), 32'd0);
    chk("rs_outstanding", 32'(outstanding), 32'd0);
    chk("rs_err_underrun", 32'(err_underrun), 32'd0);
    chk("rs_err_spurious", 32'(err_spurious), 32'd0);
    chk("rs_ready", 32'(tgt_ready), 32'd1);
    res_ready = 1'b1;
    exp_q.push_back('{score: 11'h007, len: LW'(3), to: 1'b0});
    send_seq(16'h0024, 3);
    pulse(12'h807);
    drain();
    chk("rs_outstanding_0", 32'(outstanding), 32'd0);

`ifdef SW_DRV_TIMEOUT_EN
    exp_q.push_back('{score: 11'h000, len: LW'(3), to: 1'b1});
    send_seq(16'h0039, 3);
    for (int i = 0; i < 23; i++) begin
      step();
      chk("to_early", 32'(res_valid), 32'd0);
    end
    step();
    chk("to_res_valid", 32'(res_valid), 32'd1);
    chk("to_flag", 32'(res_timeout), 32'd1);
    drain();
    pulse(12'h833);
    chk("to_late_spurious", 32'(err_spurious), 32'd1);
`endif

    repeat (3) step();
    chk("final_pending", 32'(exp_q.size()), 32'd0);
    chk("pe_en_cycles", 32'(en_cnt), 32'(exp_en));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
